// File: rtl/test_image_gen_pkg.sv
// Shared mode encodings and pixel-alignment helper for the test-pattern inserter.
package test_image_pkg;

  typedef enum logic [2:0] {
    SEL_PASS     = 3'b000,
    SEL_FRAME    = 3'b001,
    SEL_DIAG     = 3'b010,
    SEL_HRAMP    = 3'b011,
    SEL_VRAMP    = 3'b100,
    SEL_CHECK    = 3'b101,
    SEL_CONST    = 3'b110,
    SEL_PASS_ALT = 3'b111
  } test_sel_e;

  // Places a cnt_w-bit counter value in the top bits of a pix_w-bit pixel, LSBs zero.
  function automatic logic [31:0] msb_align(input logic [31:0] v,
                                             input int unsigned cnt_w,
                                             input int unsigned pix_w);
    logic [31:0] mask;
    mask = (32'd1 << cnt_w) - 32'd1;
    return (v & mask) << (pix_w - cnt_w);
  endfunction

endpackage

// File: rtl/test_image_gen_if.sv
// Sensor-side bus into and image-side bus out of the test-pattern inserter.
interface test_image_gen_if #(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4
);
  logic                                    i_fval;
  logic                                    i_lval;
  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data;
  logic [2:0]                              iv_test_image_sel;
  logic [SENSOR_DAT_WIDTH-1:0]             iv_const_value;
  logic                                    o_fval;
  logic                                    o_lval;
  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data;
  logic [2:0]                              ov_active_sel;

  modport master (
    output i_fval, i_lval, iv_pix_data, iv_test_image_sel, iv_const_value,
    input  o_fval, o_lval, ov_pix_data, ov_active_sel
  );

  modport slave (
    input  i_fval, i_lval, iv_pix_data, iv_test_image_sel, iv_const_value,
    output o_fval, o_lval, ov_pix_data, ov_active_sel
  );
endinterface

// File: rtl/test_image_gen_timing.sv
// Frame/line edge detection, post-reset arming, frame-boundary mode latch and
// the frame/line/column counters that feed the pattern generators.
module test_image_timing
  import test_image_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int CHANNEL_NUM = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fval_i,
  input  logic                 lval_i,
  input  logic [2:0]           sel_i,
  output logic                 armed_o,
  output test_sel_e            active_sel_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic [CNT_WIDTH-1:0] line_cnt_o,
  output logic [CNT_WIDTH-1:0] col_cnt_o
);

  logic                 fval_q, lval_q, armed_q;
  logic                 lval_d, armed_d;
  test_sel_e            sel_q, sel_d;
  logic [CNT_WIDTH-1:0] frame_q, frame_d, line_q, line_d, col_q, col_d;
  logic                 fval_fall, lval_fall;

  always_comb begin
    lval_d    = fval_i & lval_i;
    fval_fall = fval_q & ~fval_i;
    lval_fall = lval_q & ~lval_d;
    armed_d   = armed_q | ~fval_i;
    sel_d     = fval_i ? sel_q : test_sel_e'(sel_i);
    frame_d   = (fval_fall & armed_q) ? frame_q + 1'b1 : frame_q;
    // Clearing outside the frame takes priority over a coincident line end.
    if (!fval_i)        line_d = '0;
    else if (lval_fall) line_d = line_q + 1'b1;
    else                line_d = line_q;
    col_d = (lval_d & armed_q) ? col_q + CNT_WIDTH'(CHANNEL_NUM) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      armed_q <= 1'b0;
      sel_q   <= SEL_PASS;
      frame_q <= '0;
      line_q  <= '0;
      col_q   <= '0;
    end else begin
      fval_q  <= fval_i;
      lval_q  <= lval_d;
      armed_q <= armed_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      line_q  <= line_d;
      col_q   <= col_d;
    end
  end

  assign armed_o      = armed_q;
  assign active_sel_o = sel_q;
  assign frame_cnt_o  = frame_q;
  assign line_cnt_o   = line_q;
  assign col_cnt_o    = col_q;

endmodule

// File: rtl/test_image_gen.sv
// Test-pattern inserter: passes sensor pixels through or substitutes synthetic
// patterns. Define TEST_IMAGE_STAT_EN to add last-frame/last-line size outputs.
module test_image_gen
  import test_image_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int CNT_WIDTH        = 8,
  parameter int CHECKER_SHIFT    = 3
) (
  input  logic              clk,
  input  logic              reset,
  test_image_gen_if.slave   bus
`ifdef TEST_IMAGE_STAT_EN
  ,
  output logic [15:0]       ov_frame_lines,
  output logic [15:0]       ov_line_pixels
`endif
);

  localparam int W     = SENSOR_DAT_WIDTH;
  localparam int PIX_W = SENSOR_DAT_WIDTH * CHANNEL_NUM;

  logic                 armed, active;
  test_sel_e            active_sel;
  logic [CNT_WIDTH-1:0] frame_cnt, line_cnt, col_cnt;
  logic [CNT_WIDTH-1:0] kc, col_k, diag;
  logic [W-1:0]         ch;
  logic                 o_fval_q, o_fval_d, o_lval_q, o_lval_d;
  logic [PIX_W-1:0]     pix_q, pix_d;

  function automatic logic checker_bit(input logic [CNT_WIDTH-1:0] v);
    logic [31:0] x;
    x = 32'(v);
    return x[CHECKER_SHIFT];
  endfunction

  test_image_timing #(
    .CNT_WIDTH   (CNT_WIDTH),
    .CHANNEL_NUM (CHANNEL_NUM)
  ) u_timing (
    .clk_i        (clk),
    .rst_i        (reset),
    .fval_i       (bus.i_fval),
    .lval_i       (bus.i_lval),
    .sel_i        (bus.iv_test_image_sel),
    .armed_o      (armed),
    .active_sel_o (active_sel),
    .frame_cnt_o  (frame_cnt),
    .line_cnt_o   (line_cnt),
    .col_cnt_o    (col_cnt)
  );

  assign active   = armed & bus.i_fval & bus.i_lval;
  assign o_fval_d = armed & bus.i_fval;
  assign o_lval_d = active;

  always_comb begin
    pix_d = '0;
    kc    = '0;
    col_k = '0;
    diag  = '0;
    ch    = '0;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      kc    = CNT_WIDTH'(k);
      col_k = col_cnt + kc;
      diag  = frame_cnt + line_cnt + col_k;
      case (active_sel)
        SEL_FRAME: ch = W'(msb_align(32'(frame_cnt), CNT_WIDTH, W));
        SEL_DIAG:  ch = W'(msb_align(32'(diag), CNT_WIDTH, W));
        SEL_HRAMP: ch = W'(msb_align(32'(col_k), CNT_WIDTH, W));
        SEL_VRAMP: ch = W'(msb_align(32'(line_cnt), CNT_WIDTH, W));
        SEL_CHECK: ch = (checker_bit(col_k) ^ checker_bit(line_cnt)) ? '1 : '0;
        SEL_CONST: ch = bus.iv_const_value;
        default:   ch = bus.iv_pix_data[k*W +: W];
      endcase
      pix_d[k*W +: W] = ch;
    end
    if (!active) pix_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_fval_q <= 1'b0;
      o_lval_q <= 1'b0;
      pix_q    <= '0;
    end else begin
      o_fval_q <= o_fval_d;
      o_lval_q <= o_lval_d;
      pix_q    <= pix_d;
    end
  end

  assign bus.o_fval        = o_fval_q;
  assign bus.o_lval        = o_lval_q;
  assign bus.ov_pix_data   = pix_q;
  assign bus.ov_active_sel = active_sel;

`ifdef TEST_IMAGE_STAT_EN
  logic [15:0] lines_acc_q, pix_acc_q, frame_lines_q, line_pixels_q;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
    logic [16:0] s;
    s = {1'b0, a} + b;
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Lines are counted on armed line starts; pixels accumulate per armed beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      lines_acc_q   <= '0;
      pix_acc_q     <= '0;
      frame_lines_q <= '0;
      line_pixels_q <= '0;
    end else begin
      if (!bus.i_fval)             lines_acc_q <= '0;
      else if (active & ~o_lval_q) lines_acc_q <= sat_add(lines_acc_q, 17'd1);
      if (o_fval_q & ~bus.i_fval)  frame_lines_q <= lines_acc_q;
      if (active) pix_acc_q <= sat_add(pix_acc_q, 17'(CHANNEL_NUM));
      else        pix_acc_q <= '0;
      if (o_lval_q & ~active)      line_pixels_q <= pix_acc_q;
    end
  end

  assign ov_frame_lines = frame_lines_q;
  assign ov_line_pixels = line_pixels_q;
`endif

endmodule

// File: tb/tb_test_image_gen.sv
// Randomised scoreboard bench for test_image_gen with a frame/line/beat-level reference model.
module tb_test_image_gen;
  import test_image_pkg::*;

  localparam int W  = 10;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int CS = 2;
  localparam int PW = W * CH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  test_image_gen_if #(.SENSOR_DAT_WIDTH(W), .CHANNEL_NUM(CH)) bus ();

`ifdef TEST_IMAGE_STAT_EN
  logic [15:0] frame_lines, line_pixels;
`endif

  test_image_gen #(
    .SENSOR_DAT_WIDTH (W),
    .CHANNEL_NUM      (CH),
    .CNT_WIDTH        (CW),
    .CHECKER_SHIFT    (CS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef TEST_IMAGE_STAT_EN
    ,
    .ov_frame_lines (frame_lines),
    .ov_line_pixels (line_pixels)
`endif
  );

  typedef struct {
    int            stamp;
    logic          fv;
    logic          lv;
    logic [PW-1:0] pix;
    logic [2:0]    sel;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  bit         m_armed;
  bit         m_prev_fv;
  logic [2:0] m_sel;
  int         m_frame;
  logic [2:0] sel_req;
  bit         pat_fixed;
  logic [PW-1:0] pat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] ref_pix(input logic [2:0] mode, input logic [PW-1:0] din,
                                            input logic [W-1:0] cval, input int line, input int beat);
    logic [PW-1:0] r;
    logic [W-1:0]  p;
    int col, v;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      col = beat * CH + k;
      case (mode)
        3'd1:    v = m_frame;
        3'd2:    v = m_frame + line + col;
        3'd3:    v = col;
        3'd4:    v = line;
        default: v = 0;
      endcase
      p = W'((v % (1 << CW)) << (W - CW));
      case (mode)
        3'd0, 3'd7: p = din[k*W +: W];
        3'd5: p = ((((col % (1 << CW)) >> CS) ^ ((line % (1 << CW)) >> CS)) & 1) != 0 ? '1 : '0;
        3'd6: p = cval;
        default: ;
      endcase
      r[k*W +: W] = p;
    end
    return r;
  endfunction

  task automatic step(input logic rst, input logic fv, input logic lv, input int line, input int beat);
    logic [PW-1:0] din;
    logic [W-1:0]  cv;
    exp_t e;
    @(posedge clk);
    #1;
    din = pat_fixed ? pat : PW'({$urandom(), $urandom()});
    cv  = W'($urandom());
    reset                 = rst;
    bus.i_fval            = fv;
    bus.i_lval            = lv;
    bus.iv_pix_data       = din;
    bus.iv_test_image_sel = sel_req;
    bus.iv_const_value    = cv;
    e.stamp = cyc + 1;
    if (rst) begin
      e.fv = 1'b0; e.lv = 1'b0; e.pix = '0; e.sel = 3'd0;
      m_armed = 0; m_prev_fv = 0; m_sel = 3'd0; m_frame = 0;
    end else begin
      e.fv  = m_armed && fv;
      e.lv  = m_armed && fv && lv;
      e.pix = (m_armed && fv && lv) ? ref_pix(m_sel, din, cv, line, beat) : '0;
      if (!fv) m_sel = sel_req;
      e.sel = m_sel;
      if (m_prev_fv && !fv && m_armed) m_frame++;
      if (!fv) m_armed = 1;
      m_prev_fv = fv;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // One frame; drop=1 ends fval together with the last lval. chg_line/rst_line < 0 disable.
  task automatic frame(input int nl, input int nb, input bit drop,
                       input int chg_line, input logic [2:0] chg_sel, input int rst_line);
    for (int l = 0; l < nl; l++) begin
      if (l == chg_line) sel_req = chg_sel;
      for (int b = 0; b < nb; b++) begin
        if (l == rst_line && b == 0) step(1'b1, 1'b1, 1'b1, l, b);
        else                         step(1'b0, 1'b1, 1'b1, l, b);
      end
      if (!(drop && l == nl - 1))
        repeat (1 + $urandom_range(1)) step(1'b0, 1'b1, 1'b0, l, 0);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.stamp != cyc || bus.o_fval !== mon_e.fv || bus.o_lval !== mon_e.lv ||
          bus.ov_pix_data !== mon_e.pix || bus.ov_active_sel !== mon_e.sel) begin
        errors++;
        $display("FAIL out_cyc%0d: got fv=%b lv=%b pix=%h sel=%0d, required fv=%b lv=%b pix=%h sel=%0d",
                 cyc, bus.o_fval, bus.o_lval, bus.ov_pix_data, bus.ov_active_sel,
                 mon_e.fv, mon_e.lv, mon_e.pix, mon_e.sel);
      end
    end
  end

  initial begin
    int wait_cyc;
    reset = 1'b1;
    bus.i_fval = 1'b0; bus.i_lval = 1'b0; bus.iv_pix_data = '0;
    bus.iv_test_image_sel = 3'd0; bus.iv_const_value = '0;
    sel_req = 3'd0; pat_fixed = 0; pat = '0;
    m_armed = 0; m_prev_fv = 0; m_sel = 3'd0; m_frame = 0;

    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);

    // Passthrough with a fixed word
    idle(1);
    pat_fixed = 1; pat = 40'h0000401004;
    frame(2, 4, 0, -1, 3'd0, -1);
    idle(2);
    pat_fixed = 0;

    // Horizontal ramp
    sel_req = 3'd3;
    idle(2);
    frame(2, 3, 0, -1, 3'd0, -1);
    idle(2);

    // Mode request changes mid-frame, applied next frame
    frame(3, 2, 0, 1, 3'd4, -1);
    idle(2);
    frame(3, 2, 1, -1, 3'd0, -1);
    idle(2);

    // Frame counter wrap
    sel_req = 3'd1;
    step(1'b1, 1'b0, 1'b0, 0, 0);
    idle(1);
    repeat (257) begin
      frame(1, 1, 1, -1, 3'd0, -1);
      idle(1);
    end

    // Reset during line 2 with fval held, then a normal frame
    sel_req = 3'd3;
    idle(1);
    frame(4, 3, 0, -1, 3'd0, 2);
    idle(2);
    frame(2, 3, 0, -1, 3'd0, -1);
    idle(2);

    // Checkerboard, diagonal, constant
    sel_req = 3'd5; idle(1); frame(6, 2, 0, -1, 3'd0, -1); idle(2);
    sel_req = 3'd2; idle(1); frame(3, 3, 1, -1, 3'd0, -1); idle(2);
    sel_req = 3'd6; idle(1); frame(2, 2, 0, -1, 3'd0, -1); idle(2);

    // Randomised frames and modes
    for (int i = 0; i < 60; i++) begin
      sel_req = 3'($urandom_range(7));
      idle(1 + $urandom_range(2));
      frame(1 + $urandom_range(3), 1 + $urandom_range(3), bit'($urandom_range(1)),
            ($urandom_range(3) == 0) ? int'($urandom_range(2)) : -1, 3'($urandom_range(7)),
            ($urandom_range(7) == 0) ? int'($urandom_range(2)) : -1);
    end
    idle(3);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/test_image_gen.md
Name: test_image_gen

Overview:
- Parametrised successor test-pattern inserter.
- Sits between the sensor deserialiser and the image pipeline.
- Takes the sensor's fval/lval/pixel bus and either passes the pixels through or replaces them with one of several synthetic patterns, selectable at runtime.
- Adds synchronous reset, frame-boundary mode switching, wider counters, ramp/checkerboard/constant patterns and a post-reset re-arm.

Parameters:
- SENSOR_DAT_WIDTH, 10: bits per pixel per channel.
- CHANNEL_NUM, 4: pixels per clock beat.
- CNT_WIDTH, 8: width of frame/line/column counters. Must satisfy 1 ≤ CNT_WIDTH ≤ SENSOR_DAT_WIDTH.
- CHECKER_SHIFT, 3: checkerboard square size = 2^CHECKER_SHIFT pixels/lines.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- i_fval  in  1  frame valid.
- i_lval  in  1  line valid; meaningful only while i_fval=1.
- iv_pix_data  in  SENSOR_DAT_WIDTH*CHANNEL_NUM  sensor pixels; channel k occupies bits [W*(k+1)-1 : W*k].
- iv_test_image_sel  in  3  requested mode.
- iv_const_value  in  SENSOR_DAT_WIDTH  pixel value for constant mode.
- o_fval  out  1  frame valid, delayed 1 cycle.
- o_lval  out  1  line valid, delayed 1 cycle, gated by fval.
- ov_pix_data  out  SENSOR_DAT_WIDTH*CHANNEL_NUM  output pixels.
- ov_active_sel  out  3  mode currently applied.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high.
- Reset values: o_fval=0, o_lval=0, ov_pix_data=0, ov_active_sel=000, all counters=0, armed=0.
- Arming:
  - After reset, armed=0 and o_fval/o_lval are forced 0.
  - armed sets on the first cycle with i_fval=0. This prevents emitting a partial frame.
- Latency: exactly 1 cycle on every output.
  - o_fval = armed & i_fval, registered.
  - o_lval = armed & i_fval & i_lval, registered.
- Active beat: i_fval & i_lval & armed. Outside active beats, ov_pix_data=0.
- Mode latch:
  - active_sel loads iv_test_image_sel on every cycle with i_fval=0.
  - It holds while i_fval=1, so a mode change mid-frame takes effect from the next frame.
- Counters (modulo 2^CNT_WIDTH, wrap silently):
  - frame_cnt: +1 on each i_fval falling edge while armed, in all modes.
  - line_cnt: cleared while i_fval=0; +1 on each lval falling edge inside the frame.
  - col_cnt: cleared on non-active beats; +CHANNEL_NUM per active beat.
- Pixel value per channel k (value v computed with counters sampled before their update this cycle):
  - 000: passthrough of iv_pix_data.
  - 001: v = frame_cnt, same for all channels.
  - 010: v = frame_cnt + line_cnt + col_cnt + k (moving diagonal).
  - 011: v = col_cnt + k (horizontal ramp).
  - 100: v = line_cnt (vertical ramp).
  - 101: pixel = all ones if bit CHECKER_SHIFT of (col_cnt+k) XOR bit CHECKER_SHIFT of line_cnt is 1, else 0.
  - 110: pixel = iv_const_value.
  - 111: passthrough.
- Width rule: the CNT_WIDTH-bit v is MSB-aligned, zero-padded in the LSBs: {v, (W-CNT_WIDTH) zeros}.
- Simultaneous fval fall and lval fall: frame_cnt increments and line_cnt clears; clear wins.
- Reset mid-frame: outputs go 0 on the next edge, the frame is dropped, and the generator re-arms at the next i_fval=0.

Optional Feature:
- Macro: TEST_IMAGE_STAT_EN.
- Defined: adds two outputs.
  - ov_frame_lines [15:0]: lines counted in the last frame, captured at the fval falling edge.
  - ov_line_pixels [15:0]: pixels (beats × CHANNEL_NUM) in the last line, captured at the lval falling edge.
  - Both reset to 0 and use independent 16-bit counters, saturating at 0xFFFF.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package test_image_pkg holds:
  - mode encodings as named constants: SEL_PASS=000, SEL_FRAME=001, SEL_DIAG=010, SEL_HRAMP=011, SEL_VRAMP=100, SEL_CHECK=101, SEL_CONST=110.
  - a function returning the MSB-aligned pixel from a counter value.
- One sub-module, test_image_timing, owns edge detection, arming, the mode latch and the three counters.
- The top level instantiates test_image_timing and generates the per-channel pixel muxes.

Test Plan:
(All cases use W=10, CHANNEL_NUM=4, CNT_WIDTH=8 unless stated.)
1. Passthrough: reset, one idle cycle, mode 000, frame of 2 lines × 4 beats with iv_pix_data=0x0401004 → same word on ov_pix_data 1 cycle later. o_fval/o_lval equal the inputs delayed 1 cycle.
2. Horizontal ramp, mode 011:
   - Beat 0 → channels 0x000, 0x004, 0x008, 0x00C.
   - Beat 1 → 0x010, 0x014, 0x018, 0x01C.
   - Line 1 beat 0 restarts at 0x000.
3. Mode switch mid-frame: mode 011 active, iv_test_image_sel→100 during line 1 → ov_active_sel stays 011 until i_fval=0. Next frame line 2 outputs 0x008 on all channels.
4. Frame-counter wrap, mode 001: 257 frames of 1 line × 1 beat → frames 0..255 output v=0..255 (0x000..0x3FC); frame 256 outputs 0x000.
5. Reset mid-frame: assert reset during line 2 with i_fval held 1 → outputs 0 next cycle. o_fval stays 0 until i_fval drops, then follows the next frame normally.
6. Checkerboard, CHECKER_SHIFT=2, mode 101:
   - Line 0, columns 0–3 = 0x000; columns 4–7 = 0x3FF.
   - Line 4, columns 0–3 = 0x3FF.
